// File: rtl/bus_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bus_arbiter_pkg
// Description : Shared bus header for the four-master round-robin arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package bus_arbiter_pkg;

  localparam int MASTER_NUM       = 4;
  localparam int MAX_HOLD_DEFAULT = 16;

  typedef logic [1:0] owner_t;

  localparam owner_t OWNER_M0 = 2'd0;
  localparam owner_t OWNER_M1 = 2'd1;
  localparam owner_t OWNER_M2 = 2'd2;
  localparam owner_t OWNER_M3 = 2'd3;

  typedef logic [0:0] state_t;

  localparam state_t ST_IDLE = 1'b0;
  localparam state_t ST_BUSY = 1'b1;

  // Active-low one-hot grant vector for a given owner.
  function automatic logic [MASTER_NUM-1:0] grant_decode(input owner_t own);
    logic [MASTER_NUM-1:0] g;
    g      = '1;
    g[own] = 1'b0;
    return g;
  endfunction

  function automatic logic [MASTER_NUM-1:0] owner_mask(input owner_t own);
    logic [MASTER_NUM-1:0] m;
    m      = '0;
    m[own] = 1'b1;
    return m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bus_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : bus_arbiter_if
// Description : Request/grant bundle between four bus masters and the arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface bus_arbiter_if;

  logic       m0_req_;
  logic       m1_req_;
  logic       m2_req_;
  logic       m3_req_;
  logic       m0_grnt_;
  logic       m1_grnt_;
  logic       m2_grnt_;
  logic       m3_grnt_;
  logic [1:0] owner;
  logic       arb_tmo;

  modport master (
    output m0_req_, m1_req_, m2_req_, m3_req_,
    input  m0_grnt_, m1_grnt_, m2_grnt_, m3_grnt_, owner, arb_tmo
  );

  modport slave (
    input  m0_req_, m1_req_, m2_req_, m3_req_,
    output m0_grnt_, m1_grnt_, m2_grnt_, m3_grnt_, owner, arb_tmo
  );

endinterface
`default_nettype wire

// File: rtl/bus_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : bus_rr_pick
// Description : Combinational round-robin search starting after a given owner.
// Revision    : 1.0 - initial release
// ============================================================================
module bus_rr_pick
  import bus_arbiter_pkg::*;
(
  input  logic [MASTER_NUM-1:0] req_i,
  input  owner_t                start_i,
  input  logic                  excl_i,
  output owner_t                pick_o,
  output logic                  valid_o
);

  owner_t idx;

  // Search order start+1, start+2, start+3, start; the last slot is skipped
  // when the current owner must be excluded.
  always_comb begin
    pick_o  = start_i;
    valid_o = 1'b0;
    idx     = start_i;
    for (int k = 1; k <= MASTER_NUM; k++) begin
      idx = start_i + owner_t'(k);
      if (!valid_o && req_i[idx] && !(excl_i && (k == MASTER_NUM))) begin
        pick_o  = idx;
        valid_o = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : bus_arbiter
// Description : Four-master round-robin bus arbiter with hold-time timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = MAX_HOLD_DEFAULT
)
(
  input  logic         clk,
  input  logic         reset_,
  bus_arbiter_if.slave bus
);

  localparam int                HOLD_W   = $clog2(MAX_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD - 1);

  state_t                state_q, state_d;
  owner_t                owner_q, owner_d;
  logic [HOLD_W-1:0]     hold_q, hold_d;
  logic                  tmo_q, tmo_d;
  logic [MASTER_NUM-1:0] grnt_q, grnt_d;

  logic [MASTER_NUM-1:0] req;
  logic                  owner_req;
  logic                  pick_excl;
  owner_t                pick;
  logic                  pick_valid;

  assign req       = ~{bus.m3_req_, bus.m2_req_, bus.m1_req_, bus.m0_req_};
  assign owner_req = |(req & owner_mask(owner_q));
  // Only a still-requesting owner is excluded; a releasing owner is not
  // requesting so the plain search already skips it.
  assign pick_excl = (state_q == ST_BUSY) && owner_req;

  bus_rr_pick u_rr_pick (
    .req_i   (req),
    .start_i (owner_q),
    .excl_i  (pick_excl),
    .pick_o  (pick),
    .valid_o (pick_valid)
  );

  always_ff @(posedge clk) begin
    if (!reset_) begin
      state_q <= ST_IDLE;
      owner_q <= OWNER_M3;
      hold_q  <= '0;
      tmo_q   <= 1'b0;
      grnt_q  <= '1;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      hold_q  <= hold_d;
      tmo_q   <= tmo_d;
      grnt_q  <= grnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    hold_d  = hold_q;
    tmo_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        hold_d = '0;
        if (pick_valid) begin
          state_d = ST_BUSY;
          owner_d = pick;
        end
      end
      default: begin
        if (!owner_req) begin
          hold_d = '0;
          if (pick_valid) begin
            owner_d = pick;
          end else begin
            state_d = ST_IDLE;
          end
        end else if ((hold_q == HOLD_MAX) && pick_valid) begin
          owner_d = pick;
          hold_d  = '0;
          tmo_d   = 1'b1;
        end else if (hold_q != HOLD_MAX) begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
    endcase
  end

  always_comb begin
    grnt_d = '1;
    if (state_d == ST_BUSY) begin
      grnt_d = grant_decode(owner_d);
    end
  end

  assign bus.m0_grnt_ = grnt_q[0];
  assign bus.m1_grnt_ = grnt_q[1];
  assign bus.m2_grnt_ = grnt_q[2];
  assign bus.m3_grnt_ = grnt_q[3];
  assign bus.owner    = owner_q;
  assign bus.arb_tmo  = tmo_q;

endmodule
`default_nettype wire

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
Parameters:
REQ-001 The block SHALL have parameter MAX_HOLD, default 16, giving the maximum consecutive cycles an owner may keep the bus while another master waits; legal range 2..256.

Ports:
REQ-002 The block SHALL have port clk, input, 1 bit: single clock; all state updates on rising edge.
REQ-003 The block SHALL have port reset_, input, 1 bit: reset, synchronous, active-low.
REQ-004 The block SHALL have ports m0_req_..m3_req_, input, 1 bit each: bus request from master n, active-low.
REQ-005 The block SHALL have ports m0_grnt_..m3_grnt_, output, 1 bit each: registered grant to master n, active-low; these drive the master-select grant inputs of the downstream bus master multiplexer.
REQ-006 The block SHALL have port owner, output, 2 bits: index of the granted master, or of the last granted master when idle.
REQ-007 The block SHALL have port arb_tmo, output, 1 bit: one-cycle active-high pulse on a forced handover.

Function
REQ-008 At most one grnt_ SHALL be low in any cycle; all grnt_ high denotes IDLE.
REQ-009 The block SHALL implement a two-state FSM: IDLE (no grant) and BUSY (exactly one grant, equal to owner).
REQ-010 Round-robin pick SHALL search masters owner+1, owner+2, owner+3, owner (modulo 4) and select the first with req_ low.
REQ-011 In IDLE, any req_ low SHALL cause the picked master's grnt_ to go low on the next edge, with FSM to BUSY and owner updated; grant latency is one cycle.
REQ-012 In IDLE with no request, all outputs SHALL hold.
REQ-013 In BUSY, if the owner's req_ is high and another master requests, the grant SHALL move directly to the RR pick on the next edge with no idle gap, and the new owner's hold counter SHALL clear.
REQ-014 In BUSY, if the owner's req_ is high and no other master requests, the FSM SHALL go to IDLE, all grnt_ go high, and owner holds.
REQ-015 In BUSY, if the owner's req_ is low, the grant SHALL hold and hold_cnt SHALL increment, saturating at MAX_HOLD-1.
REQ-016 If hold_cnt = MAX_HOLD-1, the owner's req_ is still low, and any other req_ is low, the grant SHALL move on the next edge to the RR pick excluding the current owner, and arb_tmo SHALL pulse high for that one cycle.
REQ-017 With the owner as sole requester, there SHALL be no forced handover, and hold_cnt SHALL remain saturated.
REQ-018 hold_cnt SHALL be clog2(MAX_HOLD) bits wide, clear on every new grant, and clear in IDLE.
REQ-019 Simultaneous requests SHALL be resolved only by RR order, with no fixed priority except immediately after reset.

Reset
REQ-020 While reset_ is low at a rising edge, the block SHALL set FSM to IDLE, all grnt_ to 1, owner to 3, hold_cnt to 0, and arb_tmo to 0, so that the first RR pick after reset favours master 0.
REQ-021 Reset asserted mid-ownership SHALL drop the grant on that edge, with no completion of the handover.
REQ-022 Request inputs SHALL be ignored during reset.

Structure
REQ-023 The shared bus header SHALL hold MASTER_NUM=4, the owner index encodings, the IDLE/BUSY state encodings, and the MAX_HOLD default.
REQ-024 The block SHALL contain one combinational sub-module, bus_rr_pick, with inputs 4-bit request vector, start owner, and exclude-owner flag, and outputs pick index and valid flag.
REQ-025 grnt_ outputs SHALL be registered, decoded from next owner and next state; no combinational path SHALL exist from req_ to grnt_.

Verification
REQ-026 Reset release, m2_req_=0 only: m2_grnt_ goes low 1 cycle later, owner=2, other grants stay high.
REQ-027 From reset, m0..m3 all requesting and each releasing after 3 grant cycles: grant order is 0,1,2,3, with no idle cycle between owners.
REQ-028 Owner m1 releases while m3 and m0 request: grant moves to m3 next edge, then to m0 after m3 releases.
REQ-029 MAX_HOLD=4, m0 holds req low and m2 requests from cycle 1: after 4 m0 grant cycles the grant moves to m2 and arb_tmo=1 for exactly that cycle.
REQ-030 m0 sole requester for 50 cycles: grant stays, arb_tmo stays 0, hold_cnt saturates at MAX_HOLD-1.
REQ-031 Assert reset_ low while m3 is owner: next edge gives all grnt_=1 and owner=3; after release with m3 still requesting, grant returns to m3 after 1 cycle.
REQ-032 Every cycle of every test SHALL be checked for at most one grnt_ low (one-hot-low assertion).
